// File: rtl/axi_burst_rd_master.sv
// AXI read master for the DDR2 controller read channel.
// Takes one user request (start address, beat count), issues it as a series
// of AXI bursts of at most RBURST_LEN beats with one burst in flight at a
// time, forwards returned beats to the user and pulses rd_done at the end.
module axi_burst_rd_master #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int DATA_LEVEL = 2,
  parameter int WBURST_LEN = 8,
  parameter int RBURST_LEN = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_end,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic [7:0]            axi_arlen,
  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  input  logic                  axi_rlast,
  input  logic [DATA_WIDTH-1:0] axi_rdata,
  input  logic                  rd_trig,
  input  logic [7:0]            rd_len,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_en,
  output logic                  rd_done
);

  // WBURST_LEN only shares the range rule with RBURST_LEN; this block never writes.
  if (RBURST_LEN < 1 || RBURST_LEN > 256 || WBURST_LEN < 1 || WBURST_LEN > 256) begin : g_param_check
    $error("axi_burst_rd_master: burst length parameters must lie in 1..256");
  end

  localparam logic [8:0]            RBURST_N = 9'(RBURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] BEAT_STEP = ADDR_WIDTH'(DATA_LEVEL);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_RD   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_nxt_s;        // start address of current burst
  logic [7:0]            remain_r, remain_nxt_s;    // beats not yet covered by a finished burst
  logic [8:0]            burst_n_r, burst_n_nxt_s;  // beats in current burst
  logic [8:0]            beat_cnt_r, beat_cnt_nxt_s;

  logic                  accept_s;
  logic                  beat_s;
  logic                  last_beat_s;
  logic [7:0]            remain_left_s;

  // Beats of the next burst: the remainder, clamped to the burst limit.
  function automatic logic [8:0] burst_beats_f(input logic [7:0] remain);
    if ({1'b0, remain} > RBURST_N) begin
      return RBURST_N;
    end else begin
      return {1'b0, remain};
    end
  endfunction

  // Reset gating keeps the user from handing over a request that reset would discard.
  assign rd_ready    = (state_r == ST_IDLE) && init_end && !rst;
  assign accept_s    = rd_trig && rd_ready;
  assign axi_arvalid = (state_r == ST_AR);
  assign axi_araddr  = (state_r == ST_AR) ? addr_r : {ADDR_WIDTH{1'b0}};
  assign axi_arlen   = (state_r == ST_AR) ? 8'(burst_n_r - 9'd1) : 8'd0;
  assign axi_rready  = (state_r == ST_RD);
  assign beat_s      = axi_rvalid && axi_rready;
  assign rd_data_en  = beat_s;
  assign rd_data     = beat_s ? axi_rdata : {DATA_WIDTH{1'b0}};
  assign rd_done     = (state_r == ST_DONE);

  // The local beat counter ends a burst even if the slave never raises rlast.
  assign last_beat_s   = beat_s && (axi_rlast || (beat_cnt_r == (burst_n_r - 9'd1)));
  assign remain_left_s = remain_r - burst_n_r[7:0];

  // Next-state and burst bookkeeping
  always_comb begin
    state_nxt_s    = state_r;
    addr_nxt_s     = addr_r;
    remain_nxt_s   = remain_r;
    burst_n_nxt_s  = burst_n_r;
    beat_cnt_nxt_s = beat_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          addr_nxt_s     = rd_addr;
          remain_nxt_s   = rd_len;
          burst_n_nxt_s  = burst_beats_f(rd_len);
          beat_cnt_nxt_s = 9'd0;
          if (rd_len != 8'd0) begin
            state_nxt_s = ST_AR;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_AR: begin
        if (axi_arready) begin
          state_nxt_s    = ST_RD;
          beat_cnt_nxt_s = 9'd0;
        end else begin
          state_nxt_s = ST_AR;
        end
      end
      ST_RD: begin
        if (last_beat_s) begin
          remain_nxt_s   = remain_left_s;
          addr_nxt_s     = addr_r + (ADDR_WIDTH'(burst_n_r) * BEAT_STEP);
          burst_n_nxt_s  = burst_beats_f(remain_left_s);
          beat_cnt_nxt_s = 9'd0;
          if (remain_left_s != 8'd0) begin
            state_nxt_s = ST_AR;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else if (beat_s) begin
          beat_cnt_nxt_s = beat_cnt_r + 9'd1;
        end else begin
          beat_cnt_nxt_s = beat_cnt_r;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Burst address, remaining-beat and beat counters
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r     <= {ADDR_WIDTH{1'b0}};
      remain_r   <= 8'd0;
      burst_n_r  <= 9'd0;
      beat_cnt_r <= 9'd0;
    end else begin
      addr_r     <= addr_nxt_s;
      remain_r   <= remain_nxt_s;
      burst_n_r  <= burst_n_nxt_s;
      beat_cnt_r <= beat_cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_axi_burst_rd_master.sv
// Directed bench for axi_burst_rd_master. The bench plays the AXI slave;
// expected AR bursts and returned beats are queued and checked as the DUT
// presents them.
module tb_axi_burst_rd_master;

  logic        clk100m;
  logic        rst;
  logic        init_end;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [25:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic        axi_rvalid;
  logic        axi_rready;
  logic        axi_rlast;
  logic [31:0] axi_rdata;
  logic        rd_trig;
  logic [7:0]  rd_len;
  logic [25:0] rd_addr;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        rd_data_en;
  logic        rd_done;

  typedef struct {
    logic [25:0] addr;
    logic [7:0]  len;
  } ar_t;

  ar_t         q_ar[$];
  logic [31:0] q_data[$];
  int          tests  = 0;
  int          failed = 0;

  axi_burst_rd_master dut (
    .clk         (clk100m),
    .rst         (rst),
    .init_end    (init_end),
    .axi_arvalid (axi_arvalid),
    .axi_arready (axi_arready),
    .axi_araddr  (axi_araddr),
    .axi_arlen   (axi_arlen),
    .axi_rvalid  (axi_rvalid),
    .axi_rready  (axi_rready),
    .axi_rlast   (axi_rlast),
    .axi_rdata   (axi_rdata),
    .rd_trig     (rd_trig),
    .rd_len      (rd_len),
    .rd_addr     (rd_addr),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .rd_data_en  (rd_data_en),
    .rd_done     (rd_done)
  );

  initial begin
    clk100m = 1'b0;
    forever #5 clk100m = ~clk100m;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_arvalid"}, axi_arvalid, 1'b0);
    check({tag, "_araddr"},  axi_araddr,  26'd0);
    check({tag, "_arlen"},   axi_arlen,   8'd0);
    check({tag, "_rready"},  axi_rready,  1'b0);
    check({tag, "_data_en"}, rd_data_en,  1'b0);
    check({tag, "_data"},    rd_data,     32'd0);
    check({tag, "_done"},    rd_done,     1'b0);
  endtask

  // One request with the bench acting as slave. rst_at_beat >= 0 pulses reset
  // once that many beats have been delivered and abandons the request.
  task automatic do_req(input logic [25:0] a, input logic [7:0] len, input int ar_stall,
                        input bit rv_toggle, input bit omit_rlast, input int rst_at_beat);
    ar_t         e;
    logic [25:0] ea;
    int          rem, n, slv_beats, beats_seen, stall_left, cyc;
    bit          hs, beat, done_seen, phase, exp_arv, exp_done;
    ea = a;
    rem = len;
    while (rem > 0) begin
      n = (rem > 8) ? 8 : rem;
      e.addr = ea;
      e.len  = 8'(n - 1);
      q_ar.push_back(e);
      ea  = ea + 26'(n * 2);
      rem = rem - n;
    end
    @(negedge clk100m);
    rd_addr = a;
    rd_len  = len;
    rd_trig = 1'b1;
    #1 check("rd_ready_idle", rd_ready, 1'b1);
    @(posedge clk100m);
    @(negedge clk100m);
    rd_trig = 1'b0;
    rd_addr = 26'($urandom);
    rd_len  = 8'($urandom);
    slv_beats = 0; beats_seen = 0; stall_left = ar_stall;
    done_seen = 1'b0; phase = 1'b1; cyc = 0;
    while (!done_seen) begin
      if (rst_at_beat >= 0 && beats_seen == rst_at_beat) begin
        rst = 1'b1; axi_rvalid = 1'b0; axi_arready = 1'b0; axi_rlast = 1'b0;
        @(posedge clk100m);
        @(negedge clk100m);
        #1;
        check_quiet("rst_mid");
        check("rst_mid_ready", rd_ready, 1'b0);
        rst = 1'b0;
        q_ar.delete();
        q_data.delete();
        return;
      end
      exp_arv = (q_ar.size() > 0) && (slv_beats == 0);
      axi_arready = !(exp_arv && stall_left > 0);
      if (exp_arv && stall_left > 0) stall_left--;
      axi_rvalid = (slv_beats > 0) && (!rv_toggle || phase);
      axi_rdata  = $urandom;
      axi_rlast  = axi_rvalid && (slv_beats == 1) && !omit_rlast;
      beat = axi_rvalid;
      if (beat) q_data.push_back(axi_rdata);
      #1;
      check("arvalid", axi_arvalid, exp_arv);
      if (exp_arv) begin
        check("araddr", axi_araddr, q_ar[0].addr);
        check("arlen",  axi_arlen,  q_ar[0].len);
      end
      check("rready", axi_rready, slv_beats > 0);
      check("rd_data_en", rd_data_en, beat);
      if (beat) check("rd_data", rd_data, q_data.pop_front());
      else      check("rd_data_idle", rd_data, 32'd0);
      exp_done = (q_ar.size() == 0) && (slv_beats == 0);
      check("rd_done", rd_done, exp_done);
      check("rd_ready_busy", rd_ready, 1'b0);
      hs = exp_arv && axi_arready;
      @(posedge clk100m);
      if (hs) begin
        e = q_ar.pop_front();
        slv_beats = int'(e.len) + 1;
      end else if (beat) begin
        slv_beats--;
        beats_seen++;
      end
      phase = !phase;
      cyc++;
      if (exp_done) done_seen = 1'b1;
      if (cyc > 2000) begin
        tests++;
        failed++;
        $error("FAIL timeout: request not finished after %0d cycles", cyc);
        done_seen = 1'b1;
      end
      @(negedge clk100m);
    end
    axi_rvalid = 1'b0; axi_arready = 1'b0; axi_rlast = 1'b0;
    #1;
    check("rd_done_single", rd_done, 1'b0);
    check("rd_ready_after", rd_ready, 1'b1);
    check("beat_total", beats_seen, len);
  endtask

  // Directed sequence
  initial begin
    rst = 1'b1; init_end = 1'b0; rd_trig = 1'b1; rd_len = 8'd4; rd_addr = 26'h40;
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rdata = 32'd0;
    repeat (2) begin
      @(negedge clk100m); #1;
      check_quiet("reset");
      check("reset_ready", rd_ready, 1'b0);
    end
    init_end = 1'b1;
    repeat (2) begin
      @(negedge clk100m); #1;
      check("rst_hold_ready", rd_ready, 1'b0);
      check("rst_hold_arvalid", axi_arvalid, 1'b0);
    end
    @(negedge clk100m);
    rst = 1'b0; init_end = 1'b0;
    repeat (4) begin
      @(negedge clk100m); #1;
      check("noinit_ready", rd_ready, 1'b0);
      check("noinit_arvalid", axi_arvalid, 1'b0);
    end
    rd_trig = 1'b0; init_end = 1'b1;
    @(negedge clk100m);

    do_req(26'h0,       8'd128, 0, 1'b0, 1'b0, -1);
    do_req(26'h100,     8'd20,  5, 1'b0, 1'b0, -1);
    do_req(26'h3FFFFF8, 8'd12,  0, 1'b1, 1'b0, -1);
    do_req(26'h200,     8'd9,   2, 1'b1, 1'b1, -1);
    do_req(26'h55,      8'd0,   0, 1'b0, 1'b0, -1);
    do_req(26'h1234,    8'd255, 1, 1'b0, 1'b0, -1);
    do_req(26'h800,     8'd20,  0, 1'b0, 1'b0, 11);

    repeat (10) begin
      @(negedge clk100m); #1;
      check("post_rst_done", rd_done, 1'b0);
      check("post_rst_arvalid", axi_arvalid, 1'b0);
    end
    check("post_rst_ready", rd_ready, 1'b1);

    do_req(26'h20, 8'd3, 0, 1'b0, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
